// File: rtl/domain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : domain_sequencer
// Description : Power-domain on/off sequencer (start, drain, quiesce, stop).
//               Optional drain timeout enabled by DOMAIN_SEQUENCER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module domain_sequencer #(
   parameter int QUIESCE_CYCLES = 12,
   parameter int DRAIN_TIMEOUT  = 1024
) (
   input  logic clk,
   input  logic async_rst,
   input  logic power_req,
   input  logic domain_init,
   input  logic drain_ack,
   output logic domain_enable,
   output logic drain_req,
   output logic domain_ready,
   output logic domain_off
`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
   ,
   output logic drain_timeout
`endif
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_STARTING = 3'd1,
      ST_ACTIVE   = 3'd2,
      ST_DRAINING = 3'd3,
      ST_STOPPING = 3'd4
   } state_t;

   localparam logic [7:0] C_QUIESCE_LOAD = 8'(QUIESCE_CYCLES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_quiesce;
   logic       w_drain_expire;
   logic       r_domain_enable;
   logic       r_drain_req;
   logic       r_domain_ready;
   logic       r_domain_off;

`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
   localparam logic [15:0] C_DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);

   logic [15:0] r_drain_cnt;
   logic        r_drain_timeout;

   // Counter holds (cycles spent draining - 1), so the last allowed cycle matches C_DRAIN_LAST.
   assign w_drain_expire = (r_drain_cnt == C_DRAIN_LAST);

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_drain_cnt     <= '0;
         r_drain_timeout <= 1'b0;
      end else begin
         if (w_next == ST_DRAINING && r_state != ST_DRAINING)
            r_drain_cnt <= '0;
         else if (r_state == ST_DRAINING)
            r_drain_cnt <= r_drain_cnt + 16'd1;

         if (r_state == ST_DRAINING && w_drain_expire && !drain_ack)
            r_drain_timeout <= 1'b1;
         else if (r_state == ST_OFF && power_req)
            r_drain_timeout <= 1'b0;
      end
   end

   assign drain_timeout = r_drain_timeout;
`else
   assign w_drain_expire = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_OFF:      if (power_req) w_next = ST_STARTING;
         ST_STARTING: begin
            if (!power_req)       w_next = ST_STOPPING;
            else if (domain_init) w_next = ST_ACTIVE;
         end
         ST_ACTIVE:   if (!power_req) w_next = ST_DRAINING;
         ST_DRAINING: if (drain_ack || w_drain_expire) w_next = ST_STOPPING;
         ST_STOPPING: if (r_quiesce == 8'd0) w_next = ST_OFF;
         default:     w_next = ST_OFF;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state register.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_state         <= ST_OFF;
         r_quiesce       <= '0;
         r_domain_enable <= 1'b0;
         r_drain_req     <= 1'b0;
         r_domain_ready  <= 1'b0;
         r_domain_off    <= 1'b1;
      end else begin
         r_state <= w_next;

         if (w_next == ST_STOPPING && r_state != ST_STOPPING)
            r_quiesce <= C_QUIESCE_LOAD;
         else if (r_state == ST_STOPPING && r_quiesce != 8'd0)
            r_quiesce <= r_quiesce - 8'd1;

         r_domain_enable <= (w_next == ST_STARTING) || (w_next == ST_ACTIVE) ||
                            (w_next == ST_DRAINING);
         r_drain_req     <= (w_next == ST_DRAINING);
         r_domain_ready  <= (w_next == ST_ACTIVE);
         r_domain_off    <= (w_next == ST_OFF);
      end
   end

   assign domain_enable = r_domain_enable;
   assign drain_req     = r_drain_req;
   assign domain_ready  = r_domain_ready;
   assign domain_off    = r_domain_off;

endmodule
`default_nettype wire

// File: tb/tb_domain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_domain_sequencer
// Description : Self-checking bench for domain_sequencer (QUIESCE 12 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_domain_sequencer;

   localparam int TMO = 16;
`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic clk;
   logic async_rst;
   logic power_req;
   logic domain_init;
   logic drain_ack;
   logic [1:0] en_v, drn_v, rdy_v, off_v, tmo_v;

   int checks   = 0;
   int failures = 0;

   domain_sequencer #(.QUIESCE_CYCLES(12), .DRAIN_TIMEOUT(TMO)) dut (
      .clk(clk), .async_rst(async_rst), .power_req(power_req),
      .domain_init(domain_init), .drain_ack(drain_ack),
      .domain_enable(en_v[0]), .drain_req(drn_v[0]),
      .domain_ready(rdy_v[0]), .domain_off(off_v[0])
`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
      , .drain_timeout(tmo_v[0])
`endif
   );

   domain_sequencer #(.QUIESCE_CYCLES(1), .DRAIN_TIMEOUT(TMO)) dut_q1 (
      .clk(clk), .async_rst(async_rst), .power_req(power_req),
      .domain_init(domain_init), .drain_ack(drain_ack),
      .domain_enable(en_v[1]), .drain_req(drn_v[1]),
      .domain_ready(rdy_v[1]), .domain_off(off_v[1])
`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
      , .drain_timeout(tmo_v[1])
`endif
   );

`ifndef DOMAIN_SEQUENCER_TIMEOUT_EN
   assign tmo_v = 2'b00;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Domain model: flags plus remaining-quiesce and drain-age timers.
   typedef struct packed {
      logic en;
      logic rdy;
      logic drn;
      logic off;
      logic tflag;
      int   quiesce;
      int   dcount;
   } mstate_t;

   localparam mstate_t C_MRESET = '{en: 1'b0, rdy: 1'b0, drn: 1'b0, off: 1'b1,
                                    tflag: 1'b0, quiesce: 0, dcount: 0};

   mstate_t m [2];
   int      qcyc [2] = '{12, 1};

   function automatic mstate_t model_next(input mstate_t s, input int q,
                                          input logic preq, input logic init,
                                          input logic ack);
      mstate_t n = s;
      if (s.off) begin
         if (preq) begin
            n.off = 1'b0; n.en = 1'b1; n.tflag = 1'b0;
         end
      end else if (s.quiesce > 0) begin
         n.quiesce = s.quiesce - 1;
         if (n.quiesce == 0) n.off = 1'b1;
      end else if (s.drn) begin
         n.dcount = s.dcount + 1;
         if (ack || (TMO_ON && n.dcount == TMO)) begin
            if (!ack) n.tflag = 1'b1;
            n.drn = 1'b0; n.en = 1'b0; n.quiesce = q;
         end
      end else if (s.rdy) begin
         if (!preq) begin
            n.rdy = 1'b0; n.drn = 1'b1; n.dcount = 0;
         end
      end else if (s.en) begin
         if (!preq) begin
            n.en = 1'b0; n.quiesce = q;
         end else if (init) begin
            n.rdy = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge async_rst) begin
      for (int i = 0; i < 2; i++) begin
         if (async_rst) m[i] <= C_MRESET;
         else           m[i] <= model_next(m[i], qcyc[i], power_req, domain_init, drain_ack);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("cmp_enable[%0d]", i), 32'(en_v[i]),  32'(m[i].en));
         check($sformatf("cmp_drain[%0d]", i),  32'(drn_v[i]), 32'(m[i].drn));
         check($sformatf("cmp_ready[%0d]", i),  32'(rdy_v[i]), 32'(m[i].rdy));
         check($sformatf("cmp_off[%0d]", i),    32'(off_v[i]), 32'(m[i].off));
         if (TMO_ON)
            check($sformatf("cmp_timeout[%0d]", i), 32'(tmo_v[i]), 32'(m[i].tflag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic bring_up();
      power_req = 1'b1;
      tick();
      domain_init = 1'b1;
      tick();
      domain_init = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      async_rst = 1'b1; power_req = 1'b0; domain_init = 1'b0; drain_ack = 1'b0;

      // Power-up
      tick();                                             // edge 1
      check("rst_enable", en_v[0], 1'b0);
      check("rst_off", off_v[0], 1'b1);
      check("rst_ready", rdy_v[0], 1'b0);
      check("rst_drain", drn_v[0], 1'b0);
      check("rst_timeout", tmo_v[0], 1'b0);
      tick();                                             // edge 2
      async_rst = 1'b0;
      tick(); tick();                                     // edge 4
      check("pre_start_enable", en_v[0], 1'b0);
      power_req = 1'b1;
      tick();                                             // edge 5
      check("start_enable_e5", en_v[0], 1'b1);
      check("start_off_e5", off_v[0], 1'b0);
      check("model_en_e5", m[0].en, 1'b1);
      repeat (14) tick();                                 // edge 19
      check("pre_init_ready", rdy_v[0], 1'b0);
      domain_init = 1'b1;
      tick();                                             // edge 20
      domain_init = 1'b0;
      check("init_ready_e20", rdy_v[0], 1'b1);

      // Stray drain_ack and domain_init while active
      tick();
      drain_ack = 1'b1; domain_init = 1'b1;
      tick();
      domain_init = 1'b0;
      tick();
      drain_ack = 1'b0;
      check("active_ignores_ack_ready", rdy_v[0], 1'b1);
      check("active_ignores_ack_drain", drn_v[0], 1'b0);

      // Orderly shutdown
      tick();
      power_req = 1'b0;
      tick();
      check("shutdown_drain_req", drn_v[0], 1'b1);
      check("shutdown_ready_low", rdy_v[0], 1'b0);
      check("shutdown_enable_hi", en_v[0], 1'b1);
      tick(); tick();
      drain_ack = 1'b1;
      tick();                                             // enable falls: edge E
      drain_ack = 1'b0;
      check("ack_enable_low", en_v[0], 1'b0);
      check("ack_drain_low", drn_v[0], 1'b0);
      repeat (11) tick();
      check("quiesce_off_e11", off_v[0], 1'b0);
      tick();
      check("quiesce_off_e12", off_v[0], 1'b1);
      check("model_off_e12", m[0].off, 1'b1);

      // Abort during start, coincident with domain_init
      tick();
      power_req = 1'b1;
      tick();
      check("abort_start_enable", en_v[0], 1'b1);
      tick(); tick();
      power_req = 1'b0; domain_init = 1'b1;
      tick();
      domain_init = 1'b0;
      check("abort_enable_low", en_v[0], 1'b0);
      seen = rdy_v[0] | drn_v[0];
      for (int k = 0; k < 11; k++) begin
         tick();
         seen = seen | rdy_v[0] | drn_v[0];
      end
      check("abort_off_e11", off_v[0], 1'b0);
      tick();
      check("abort_off_e12", off_v[0], 1'b1);
      check("abort_no_ready_no_drain", seen, 1'b0);

`ifdef DOMAIN_SEQUENCER_TIMEOUT_EN
      // Forced stop after TMO draining cycles
      tick();
      bring_up();
      power_req = 1'b0;
      tick();                                             // draining cycle 1
      check("tmo_drain_start", drn_v[0], 1'b1);
      repeat (TMO - 1) tick();                            // draining cycle TMO
      check("tmo_last_drain", drn_v[0], 1'b1);
      check("tmo_flag_before", tmo_v[0], 1'b0);
      tick();
      check("tmo_enable_low", en_v[0], 1'b0);
      check("tmo_flag_set", tmo_v[0], 1'b1);
      check("model_tflag", m[0].tflag, 1'b1);
      repeat (12) tick();
      check("tmo_off", off_v[0], 1'b1);
      check("tmo_flag_sticky", tmo_v[0], 1'b1);
      power_req = 1'b1;
      tick();
      check("tmo_flag_cleared", tmo_v[0], 1'b0);
      // drain_ack in the expiry cycle wins
      domain_init = 1'b1;
      tick();
      domain_init = 1'b0; power_req = 1'b0;
      tick();
      repeat (TMO - 1) tick();
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      check("tmo_ack_enable_low", en_v[0], 1'b0);
      check("tmo_ack_no_flag", tmo_v[0], 1'b0);
      repeat (12) tick();
`endif

      // Reset mid-drain
      tick();
      bring_up();
      power_req = 1'b0;
      tick(); tick();
      check("mid_drain_active", drn_v[0], 1'b1);
      async_rst = 1'b1;
      #1;
      check("rst_drain_enable", en_v[0], 1'b0);
      check("rst_drain_drain", drn_v[0], 1'b0);
      check("rst_drain_off", off_v[0], 1'b1);
      tick();
      async_rst = 1'b0;
      tick();

      // Reset mid-quiesce (count 5)
      bring_up();
      power_req = 1'b0;
      tick();
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      repeat (6) tick();
      check("mid_quiesce_off", off_v[0], 1'b0);
      async_rst = 1'b1;
      #1;
      check("rst_quiesce_off", off_v[0], 1'b1);
      check("rst_quiesce_enable", en_v[0], 1'b0);
      tick();
      async_rst = 1'b0;
      tick();
      check("post_rst_off", off_v[0], 1'b1);

      // Re-request held through stopping
      bring_up();
      power_req = 1'b0;
      tick();
      drain_ack = 1'b1; power_req = 1'b1;
      tick();                                             // edge E
      drain_ack = 1'b0;
      check("rereq_enable_low", en_v[1], 1'b0);
      check("rereq_not_off", off_v[1], 1'b0);
      tick();
      check("rereq_q1_off", off_v[1], 1'b1);
      tick();
      check("rereq_q1_off_gone", off_v[1], 1'b0);
      check("rereq_q1_enable", en_v[1], 1'b1);
      repeat (10) tick();
      check("rereq_q12_off", off_v[0], 1'b1);
      tick();
      check("rereq_q12_off_gone", off_v[0], 1'b0);
      check("rereq_q12_enable", en_v[0], 1'b1);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
